// File: rtl/reg_arith_arbiter.sv
// Round-robin arbiter sharing one register-arithmetic unit
// between the fetch-side PC updater and the execute-side updater.
module reg_arith_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_op0,
    input  logic [7:0] req_x0,
    input  logic [2:0] req_v0,
    input  logic [1:0] req_op1,
    input  logic [7:0] req_x1,
    input  logic [2:0] req_v1,
    output logic [7:0] au_x,
    output logic [2:0] au_v,
    output logic       au_incr,
    output logic       au_decr,
    output logic       au_jizr,
    output logic       au_jnzr,
    input  logic [7:0] au_res,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_data,
    input  logic [1:0] rsp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] x;
        logic [2:0] v;
    } req_t;

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       win;
    req_t       cur;
    req_t       sel;
    logic [1:0] grant;
    logic [7:0] data_q;

    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        sel = grant[1] ? {req_op1, req_x1, req_v1}
                       : {req_op0, req_x0, req_v0};
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        au_x      = 8'h00;
        au_v      = 3'h0;
        au_incr   = 1'b0;
        au_decr   = 1'b0;
        au_jizr   = 1'b0;
        au_jnzr   = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                // grant is gated so reset holds req_ready low
                if (|req_valid) begin
                    req_ready = grant & {2{rst_n}};
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                au_x = cur.x;
                au_v = cur.v;
                unique case (cur.op)
                    2'b00: au_incr = 1'b1;
                    2'b01: au_decr = 1'b1;
                    2'b10: au_jizr = 1'b1;
                    2'b11: au_jnzr = 1'b1;
                    default: au_incr = 1'b0;
                endcase
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[win] = 1'b1;
                if (rsp_ready[win]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            win    <= 1'b0;
            cur    <= '0;
            data_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_valid) begin
                win    <= grant[1];
                rr_ptr <= ~grant[1];
                cur    <= sel;
            end
            if (state == EXEC) begin
                data_q <= au_res;
            end
        end
    end

    assign rsp_data = data_q;

endmodule
